// File: rtl/vga_timing_rx.sv
// Measures an incoming 800x600 VGA stream, locks on repeated identical frames and emits pixels with x/y coordinates.
// Pins to pix_* take 2 clk_40M cycles. There is no backpressure. VGA_RX_CRC_EN builds the per-frame CRC-16 of locked pixels.
module vga_timing_rx #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 4095
) (
  input  logic             clk_40M,
  input  logic             rst_n,
  input  logic             vga_hs_i,
  input  logic             vga_vs_i,
  input  logic             vga_blank_n_i,
  input  logic [7:0]       vga_r_i,
  input  logic [7:0]       vga_g_i,
  input  logic [7:0]       vga_b_i,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_valid,
  output logic [7:0]       pix_r,
  output logic [7:0]       pix_g,
  output logic [7:0]       pix_b,
  output logic             locked,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             frame_start,
  output logic             err_pulse,
  output logic [15:0]      frame_crc
);

  localparam logic [CNT_W-1:0] CMAX   = '1;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] M_LAST = CNT_W'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, VERIFY, LOCKED} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + CNT_W'(1);
  endfunction

  logic       hs_q, vs_q, blank_q, hs_d, vs_d;
  logic [7:0] r_q, g_q, b_q;

  always_ff @(posedge clk_40M or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b0;
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hs_q    <= vga_hs_i;
      vs_q    <= vga_vs_i;
      blank_q <= vga_blank_n_i;
      hs_d    <= hs_q;
      vs_d    <= vs_q;
      r_q     <= vga_r_i;
      g_q     <= vga_g_i;
      b_q     <= vga_b_i;
    end
  end

  logic ls, fs;
  assign ls = hs_d & ~hs_q;
  assign fs = vs_d & ~vs_q;

  // The cycle that detects a line start is the last cycle of the line it closes.
  logic [CNT_W-1:0] h_cnt, act_cnt, line_cnt, act_line_cnt, to_cnt;
  logic             line_seen;
  logic [CNT_W-1:0] fr_hlen, fr_hact;
  logic             fr_got, fr_bad;

  logic [CNT_W-1:0] line_len, act_len, frame_lines, frame_act, cur_hlen, cur_hact;
  logic             line_act, first_now, cur_bad, to_hit, match;

  always_comb begin
    line_len    = sat_inc(h_cnt);
    act_len     = blank_q ? sat_inc(act_cnt) : act_cnt;
    line_act    = line_seen | blank_q;
    frame_lines = ls ? sat_inc(line_cnt) : line_cnt;
    frame_act   = (ls & line_act) ? sat_inc(act_line_cnt) : act_line_cnt;
    first_now   = ls & line_act & ~fr_got;
    cur_hlen    = first_now ? line_len : fr_hlen;
    cur_hact    = first_now ? act_len : fr_hact;
    cur_bad     = fr_bad | (ls & (line_len != h_total));
    to_hit      = (to_cnt >= TO_LIM) & ~ls;
    match       = (cur_hlen == h_total) && (cur_hact == h_active) &&
                  (frame_lines == v_total) && (frame_act == v_active) && !cur_bad;
  end

  always_ff @(posedge clk_40M or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt        <= '0;
      act_cnt      <= '0;
      line_seen    <= 1'b0;
      line_cnt     <= '0;
      act_line_cnt <= '0;
      to_cnt       <= '0;
    end else begin
      h_cnt     <= ls ? '0 : sat_inc(h_cnt);
      act_cnt   <= ls ? '0 : act_len;
      line_seen <= ls ? 1'b0 : line_act;
      to_cnt    <= ls ? '0 : sat_inc(to_cnt);
      if (fs) begin
        line_cnt     <= '0;
        act_line_cnt <= '0;
      end else if (ls) begin
        line_cnt     <= sat_inc(line_cnt);
        act_line_cnt <= line_act ? sat_inc(act_line_cnt) : act_line_cnt;
      end
    end
  end

  // Per-frame shape: first active line geometry and whether any line disagreed with h_total.
  always_ff @(posedge clk_40M or negedge rst_n) begin
    if (!rst_n) begin
      fr_hlen <= '0;
      fr_hact <= '0;
      fr_got  <= 1'b0;
      fr_bad  <= 1'b0;
    end else if (fs) begin
      fr_hlen <= '0;
      fr_hact <= '0;
      fr_got  <= 1'b0;
      fr_bad  <= 1'b0;
    end else begin
      if (first_now) begin
        fr_hlen <= line_len;
        fr_hact <= act_len;
        fr_got  <= 1'b1;
      end
      if (ls && (line_len != h_total)) fr_bad <= 1'b1;
    end
  end

  state_t           state;
  logic [CNT_W-1:0] match_cnt;

  always_ff @(posedge clk_40M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      frame_start <= 1'b0;
      match_cnt   <= '0;
      h_total     <= '0;
      h_active    <= '0;
      v_total     <= '0;
      v_active    <= '0;
    end else begin
      err_pulse   <= 1'b0;
      frame_start <= 1'b0;
      if (to_hit) begin
        err_pulse <= (state == LOCKED);
        locked    <= 1'b0;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (fs) state <= MEASURE;
          end
          MEASURE: begin
            if (fs) begin
              h_total   <= cur_hlen;
              h_active  <= cur_hact;
              v_total   <= frame_lines;
              v_active  <= frame_act;
              match_cnt <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (fs) begin
              if (match) begin
                if (match_cnt == M_LAST) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end else begin
                  match_cnt <= match_cnt + CNT_W'(1);
                end
              end else begin
                h_total   <= cur_hlen;
                h_active  <= cur_hact;
                v_total   <= frame_lines;
                v_active  <= frame_act;
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if ((ls && (line_len != h_total)) || (fs && (frame_lines != v_total))) begin
              err_pulse <= 1'b1;
              locked    <= 1'b0;
              state     <= IDLE;
            end else if (fs) begin
              frame_start <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic pv_next;
  assign pv_next = blank_q & locked;

  always_ff @(posedge clk_40M or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
    end else begin
      pix_valid <= pv_next;
      pix_x     <= pv_next ? act_cnt : '0;
      pix_y     <= pv_next ? act_line_cnt : '0;
      pix_r     <= pv_next ? r_q : '0;
      pix_g     <= pv_next ? g_q : '0;
      pix_b     <= pv_next ? b_q : '0;
    end
  end

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] crc24(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] n;
    n = c;
    for (int i = 23; i >= 0; i--) begin
      n = {n[14:0], 1'b0} ^ ((n[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return n;
  endfunction

  logic [15:0] crc_run;

  // The running CRC sits at its seed whenever unlocked so the first locked frame starts clean.
  always_ff @(posedge clk_40M or negedge rst_n) begin
    if (!rst_n) begin
      crc_run   <= 16'hFFFF;
      frame_crc <= '0;
    end else if (!locked) begin
      crc_run <= 16'hFFFF;
    end else if (frame_start) begin
      frame_crc <= crc_run;
      crc_run   <= 16'hFFFF;
    end else if (pix_valid) begin
      crc_run <= crc24(crc_run, {pix_r, pix_g, pix_b});
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Scoreboard bench for vga_timing_rx on a reduced 40x12-line raster (24x8 active).
`timescale 1ns/1ps
module tb_vga_timing_rx;

  logic        clk_40M = 1'b0;
  logic        rst_n   = 1'b0;
  logic        vga_hs_i = 1'b1, vga_vs_i = 1'b1, vga_blank_n_i = 1'b0;
  logic [7:0]  vga_r_i = '0, vga_g_i = '0, vga_b_i = '0;
  logic [11:0] pix_x, pix_y, h_total, h_active, v_total, v_active;
  logic        pix_valid, locked, frame_start, err_pulse;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [15:0] frame_crc;

  vga_timing_rx dut (
    .clk_40M(clk_40M), .rst_n(rst_n),
    .vga_hs_i(vga_hs_i), .vga_vs_i(vga_vs_i), .vga_blank_n_i(vga_blank_n_i),
    .vga_r_i(vga_r_i), .vga_g_i(vga_g_i), .vga_b_i(vga_b_i),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .locked(locked), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active),
    .frame_start(frame_start), .err_pulse(err_pulse), .frame_crc(frame_crc)
  );

  always #12.5 clk_40M = ~clk_40M;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } px_t;

  px_t exp_q[$];
  int  n_cmp = 0, n_bad = 0;
  int  err_cnt = 0, fs_cnt = 0;
  logic err_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_ne(input string name, input logic [15:0] got, input logic [15:0] other);
    n_cmp++;
    if (got === other) begin
      n_bad++;
      $display("FAIL %s: got %0h, required to differ from %0h", name, got, other);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {pix_x, pix_y, pix_valid, pix_r, pix_g, pix_b, locked, h_total, h_active,
            v_total, v_active, frame_start, err_pulse, frame_crc};
  endfunction

  always @(negedge clk_40M) begin
    if (pix_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d, required no pixel", pix_x, pix_y);
      end else begin
        px_t e;
        e = exp_q.pop_front();
        if ({pix_x, pix_y, pix_r, pix_g, pix_b} !== e) begin
          n_bad++;
          $display("FAIL pixel: got x=%0d y=%0d rgb=%0h/%0h/%0h, required x=%0d y=%0d rgb=%0h/%0h/%0h",
                   pix_x, pix_y, pix_r, pix_g, pix_b, e.x, e.y, e.r, e.g, e.b);
        end
      end
    end else begin
      n_cmp++;
      if ({pix_r, pix_g, pix_b} !== 24'h0) begin
        n_bad++;
        $display("FAIL rgb_blank: got %0h, required 0", {pix_r, pix_g, pix_b});
      end
    end
    if (err_pulse) begin
      err_cnt++;
      n_cmp++;
      if (locked || err_prev) begin
        n_bad++;
        $display("FAIL err_shape: got locked=%0b prev_err=%0b, required 0/0", locked, err_prev);
      end
    end
    err_prev = err_pulse;
    if (frame_start) fs_cnt++;
  end

  task automatic drive(input logic hs, input logic vs, input logic bl,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    vga_hs_i = hs; vga_vs_i = vs; vga_blank_n_i = bl;
    vga_r_i = r; vga_g_i = g; vga_b_i = b;
    @(posedge clk_40M);
    #1;
  endtask

  // 40 clocks/line (hs low 0..3, active 10..33), 12 lines/frame (vs low 0..1, active 3..10).
  task automatic drive_frame(input int short_line, input bit expv_in, input int rst_line,
                             input bit const_rgb, input bit flip);
    bit expv;
    expv = expv_in;
    for (int l = 0; l < 12; l++) begin
      for (int h = 0; h < ((l == short_line) ? 39 : 40); h++) begin
        int x, y;
        logic act;
        logic [7:0] r, g, b;
        x = h - 10;
        y = l - 3;
        act = (l >= 3) && (l <= 10) && (h >= 10) && (h <= 33);
        if (const_rgb) begin
          r = 8'd255; g = 8'd48; b = 8'd48;
        end else begin
          r = 8'(x * 10); g = 8'(y * 31 + 5); b = 8'(x + y * 7);
          if (flip && x == 0 && y == 0) b = b ^ 8'h01;
        end
        if (!act) begin
          r = '0; g = '0; b = '0;
        end
        if (act && expv) exp_q.push_back({12'(x), 12'(y), r, g, b});
        drive(h >= 4, l >= 2, act, r, g, b);
        if (l == rst_line && h == 38) begin
          rst_n = 1'b0;
          #1;
          chk("outputs_in_reset_mid_line", all_outs(), 128'h0);
          @(posedge clk_40M);
          #1;
          rst_n = 1'b1;
          expv = 1'b0;
        end
      end
    end
  endtask

  logic [15:0] crc_a, crc_b;

  initial begin
    repeat (4) @(posedge clk_40M);
    #1;
    chk("reset_outputs", all_outs(), 128'h0);
    rst_n = 1'b1;
    repeat (8) drive(1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);

    // Initial lock: frame 0 measured, 1 and 2 verified, valid from frame 3.
    for (int f = 0; f < 3; f++) drive_frame(-1, 1'b0, -1, 1'b0, 1'b0);
    chk("locked_before_lock", locked, 1'b0);
    drive_frame(-1, 1'b1, -1, 1'b0, 1'b0);
    chk("locked_after_3_frames", locked, 1'b1);
    chk("h_total", h_total, 12'd40);
    chk("h_active", h_active, 12'd24);
    chk("v_total", v_total, 12'd12);
    chk("v_active", v_active, 12'd8);
    drive_frame(-1, 1'b1, -1, 1'b0, 1'b0);
    drive_frame(-1, 1'b1, -1, 1'b0, 1'b0);
    chk("frame_start_count_a", fs_cnt, 2);
    chk("err_count_none", err_cnt, 0);

    // Short line while locked, then relock with constant colour.
    drive_frame(1, 1'b0, -1, 1'b1, 1'b0);
    chk("err_count_short_line", err_cnt, 1);
    chk("locked_after_short_line", locked, 1'b0);
    for (int f = 0; f < 3; f++) drive_frame(-1, 1'b0, -1, 1'b1, 1'b0);
    chk("locked_before_relock", locked, 1'b0);
    drive_frame(-1, 1'b1, -1, 1'b1, 1'b0);
    chk("relocked_short_line", locked, 1'b1);
    drive_frame(-1, 1'b1, -1, 1'b1, 1'b0);
    chk("frame_start_count_b", fs_cnt, 4);

    // Stream loss: hs held high well past the timeout.
    repeat (5000) drive(1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
    chk("err_count_timeout", err_cnt, 2);
    chk("locked_after_timeout", locked, 1'b0);
    chk("geometry_held", {h_total, h_active, v_total, v_active},
        {12'd40, 12'd24, 12'd12, 12'd8});
    for (int f = 0; f < 3; f++) drive_frame(-1, 1'b0, -1, 1'b0, 1'b0);
    drive_frame(-1, 1'b1, -1, 1'b0, 1'b0);
    chk("relocked_timeout", locked, 1'b1);
    drive_frame(-1, 1'b1, -1, 1'b0, 1'b0);
    chk("frame_start_count_c", fs_cnt, 5);

    // Reset during active line 5 while locked.
    drive_frame(-1, 1'b1, 5, 1'b0, 1'b0);
    chk("locked_after_reset", locked, 1'b0);
    for (int f = 0; f < 3; f++) drive_frame(-1, 1'b0, -1, 1'b0, 1'b0);
    chk("locked_3_frames_after_reset", locked, 1'b0);
    drive_frame(-1, 1'b1, -1, 1'b0, 1'b0);
    chk("relocked_reset", locked, 1'b1);

    // CRC: frames 21 and 22 identical, frame 23 has one flipped bit.
    drive_frame(-1, 1'b1, -1, 1'b0, 1'b0);
    crc_a = frame_crc;
    drive_frame(-1, 1'b1, -1, 1'b0, 1'b1);
    crc_b = frame_crc;
    drive_frame(-1, 1'b1, -1, 1'b0, 1'b0);
`ifdef VGA_RX_CRC_EN
    chk("crc_identical_frames", crc_b, crc_a);
    chk_ne("crc_flipped_bit", frame_crc, crc_a);
`else
    chk("crc_off_a", crc_a, 16'h0);
    chk("crc_off_b", frame_crc, 16'h0);
`endif
    chk("frame_start_count_d", fs_cnt, 9);
    chk("err_count_final", err_cnt, 2);
    chk("pixels_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
